// File: rtl/median_feeder.sv
// Front end for the MEDIAN filter: serializes one parallel pixel window onto DSI/DI,
// waits for the DSO strobe and hands the captured median out through a valid/ready port.
module median_feeder #(
    parameter int WIDTH    = 8,
    parameter int N_PIXELS = 9,
    parameter int TIMEOUT  = 64
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      WIN_VALID,
    output logic                      WIN_READY,
    input  logic [N_PIXELS*WIDTH-1:0] WIN_DATA,
    output logic                      DSI,
    output logic [WIDTH-1:0]          DI,
    input  logic [WIDTH-1:0]          DO,
    input  logic                      DSO,
    output logic                      RES_VALID,
    input  logic                      RES_READY,
    output logic [WIDTH-1:0]          RES_DATA,
    output logic                      BUSY,
    output logic                      ERR
);

    localparam int IDXW  = $clog2(N_PIXELS);
    localparam int WAITW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [IDXW-1:0]           idx;
    logic [WAITW-1:0]          waitcnt;
    logic [N_PIXELS*WIDTH-1:0] shadow;
    logic [WIDTH-1:0]          res_data;
    logic                      last_pixel;
    logic                      wait_expired;

    assign last_pixel   = (idx == IDXW'(N_PIXELS - 1));
    assign wait_expired = (waitcnt == WAITW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (WIN_VALID) begin
                    state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (last_pixel) begin
                    state_next = S_WAIT;
                end
            end
            // A DSO arriving on the timeout cycle still counts as a result.
            S_WAIT: begin
                if (DSO) begin
                    state_next = S_RESULT;
                end else if (wait_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_RESULT: begin
                if (RES_READY) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The pixel index is left at the last pixel after FEED so DI keeps its final value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idx      <= '0;
            waitcnt  <= '0;
            shadow   <= '0;
            res_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    waitcnt <= '0;
                    if (WIN_VALID) begin
                        shadow <= WIN_DATA;
                        idx    <= '0;
                    end
                end
                S_FEED: begin
                    waitcnt <= '0;
                    if (!last_pixel) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    waitcnt <= waitcnt + 1'b1;
                    if (DSO) begin
                        res_data <= DO;
                    end
                end
                default: begin
                    waitcnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        WIN_READY = (state == S_IDLE);
        DSI       = (state == S_FEED);
        RES_VALID = (state == S_RESULT);
        BUSY      = (state != S_IDLE);
        ERR       = (state == S_WAIT) && !DSO && wait_expired;
        DI        = shadow[idx*WIDTH +: WIDTH];
        RES_DATA  = res_data;
    end

endmodule
